// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU: opcodes, ALU classes, instruction fields.
package cpu_pkg;
   localparam int DATA_W = 16;

   // Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, imm8 = [7:0]
   localparam int FIELD_W = 4;
   localparam int IMM_W   = 8;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;

   // Only opcode[1:0] picks the operation; the class comes from cs_alu_ot.
   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_INC   = 4'h2;
   localparam logic [3:0] OP_DEC   = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_NOT   = 4'h7;
   localparam logic [3:0] OP_LOADI = 4'hF;

   localparam logic ALU_ARITH = 1'b0;
   localparam logic ALU_LOGIC = 1'b1;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic class chosen by ot, LOADI overrides both.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        opcode,
   input  logic              ot,
   input  logic [IMM_W-1:0]  imm8,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);
   logic [DATA_W:0] sum;

   always_comb begin
      sum    = '0;
      result = '0;
      carry  = 1'b0;
      if (opcode == OP_LOADI) begin
         result = {{(DATA_W-IMM_W){1'b0}}, imm8};
      end else if (ot == ALU_ARITH) begin
         // Bit DATA_W of the widened sum is carry for adds and borrow for subtracts.
         case (opcode[1:0])
            OP_ADD[1:0]: sum = {1'b0, a} + {1'b0, b};
            OP_SUB[1:0]: sum = {1'b0, a} - {1'b0, b};
            OP_INC[1:0]: sum = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
            default:     sum = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
         endcase
         result = sum[DATA_W-1:0];
         carry  = sum[DATA_W];
      end else begin
         case (opcode[1:0])
            OP_AND[1:0]: result = a & b;
            OP_OR[1:0]:  result = a | b;
            OP_XOR[1:0]: result = a ^ b;
            default:     result = ~a;
         endcase
      end
      zero = (result == '0);
   end
endmodule

// File: rtl/cpu_datapath_core.sv
// CPU datapath: PC, IR, 16x16 register file, operand latches and ALU, driven by
// one-cycle strobes from the control unit; makes no sequencing decisions itself.
module cpu_datapath_core
   import cpu_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              cs_ins_load,
   input  logic              cs_op1_load,
   input  logic              cs_op2_load,
   input  logic              cs_alu_ot,
   input  logic              cs_reg_load,
   input  logic              cs_pc_load,
   input  logic              cs_pc_inc,
   output logic [3:0]        opcode,
   output logic              ir_valid,
   output logic              zero_flag,
   output logic              carry_flag,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   logic [DATA_W-1:0] pc, ir, op1, op2;
   logic [DATA_W-1:0] rf [16];
   logic [FIELD_W-1:0] rd, rs1, rs2;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry, alu_zero;

   assign opcode    = ir[OPC_LSB +: FIELD_W];
   assign rd        = ir[RD_LSB  +: FIELD_W];
   assign rs1       = ir[RS1_LSB +: FIELD_W];
   assign rs2       = ir[RS2_LSB +: FIELD_W];
   assign imem_addr = pc;
   assign dbg_data  = rf[dbg_sel];

   cpu_alu u_alu (
      .a      (op1),
      .b      (op2),
      .opcode (opcode),
      .ot     (cs_alu_ot),
      .imm8   (ir[IMM_W-1:0]),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // Every register samples the pre-edge IR/OP1/OP2/RF, so same-cycle strobes
   // see old values: no write-to-read bypass anywhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= PC_RESET;
         ir         <= '0;
         op1        <= '0;
         op2        <= '0;
         ir_valid   <= 1'b0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else begin
         if (cs_ins_load) begin
            ir       <= imem_data;
            ir_valid <= 1'b1;
         end
         if (cs_op1_load) op1 <= rf[rs1];
         if (cs_op2_load) op2 <= rf[rs2];
         if (cs_reg_load) begin
            rf[rd] <= alu_result;
            if (opcode != OP_LOADI) begin
               zero_flag <= alu_zero;
               if (cs_alu_ot == ALU_ARITH) carry_flag <= alu_carry;
            end
         end
         if (cs_pc_load)     pc <= op1;
         else if (cs_pc_inc) pc <= pc + 1'b1;
      end
   end
endmodule

// File: tb/tb_cpu_datapath_core.sv
// Directed bench for cpu_datapath_core with hand-computed expectations.
module tb_cpu_datapath_core;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr, imem_data, dbg_data;
   logic        cs_ins_load, cs_op1_load, cs_op2_load, cs_alu_ot;
   logic        cs_reg_load, cs_pc_load, cs_pc_inc;
   logic [3:0]  opcode, dbg_sel;
   logic        ir_valid, zero_flag, carry_flag;

   int n_chk = 0;
   int n_err = 0;

   cpu_datapath_core #(.DATA_W(16), .PC_RESET(16'h0000)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .cs_ins_load(cs_ins_load), .cs_op1_load(cs_op1_load), .cs_op2_load(cs_op2_load),
      .cs_alu_ot(cs_alu_ot), .cs_reg_load(cs_reg_load), .cs_pc_load(cs_pc_load),
      .cs_pc_inc(cs_pc_inc), .opcode(opcode), .ir_valid(ir_valid),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock with the given strobes high; returns 1 time unit after the edge.
   task automatic cyc(input logic ins, op1, op2, ot, regl, pcl, pci);
      cs_ins_load = ins; cs_op1_load = op1; cs_op2_load = op2; cs_alu_ot = ot;
      cs_reg_load = regl; cs_pc_load = pcl; cs_pc_inc = pci;
      @(posedge clk);
      #1;
      {cs_ins_load, cs_op1_load, cs_op2_load, cs_alu_ot, cs_reg_load, cs_pc_load, cs_pc_inc} = '0;
   endtask

   // Fetch, latch both operands, write back.
   task automatic exec(input logic [15:0] instr, input logic ot);
      imem_data = instr;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, ot, 1, 0, 0);
   endtask

   task automatic rd_reg(input logic [3:0] idx, output logic [15:0] val);
      dbg_sel = idx;
      #1;
      val = dbg_data;
   endtask

   logic [15:0] v;

   initial begin
      rst = 1'b1; imem_data = '0; dbg_sel = '0;
      {cs_ins_load, cs_op1_load, cs_op2_load, cs_alu_ot, cs_reg_load, cs_pc_load, cs_pc_inc} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // 1: reset state
      chk("rst_pc", imem_addr, 16'h0000);
      chk("rst_opc", {12'h0, opcode}, 16'h0);
      chk("rst_flags", {13'h0, ir_valid, zero_flag, carry_flag}, 16'h0);
      for (int i = 0; i < 16; i++) begin
         rd_reg(4'(i), v);
         chk($sformatf("rst_rf%0d", i), v, 16'h0000);
      end

      // 2: LOADI and ADD
      exec(16'hF1AB, 0);
      rd_reg(4'd1, v); chk("loadi_r1", v, 16'h00AB);
      chk("loadi_zero", {15'h0, zero_flag}, 16'h0);
      chk("ir_valid", {15'h0, ir_valid}, 16'h1);
      exec(16'hF2FF, 0);
      rd_reg(4'd2, v); chk("loadi_r2", v, 16'h00FF);
      exec(16'h0312, 0);
      rd_reg(4'd3, v); chk("add_r3", v, 16'h01AA);
      chk("add_flags", {14'h0, zero_flag, carry_flag}, 16'h0);

      // 3: carry/zero boundaries
      exec(16'h3100, 1);                       // r1 = NOT r0
      rd_reg(4'd1, v); chk("not_r1", v, 16'hFFFF);
      exec(16'hF201, 0);
      exec(16'h0312, 0);                       // FFFF + 0001
      rd_reg(4'd3, v); chk("addc_r3", v, 16'h0000);
      chk("addc_flags", {14'h0, zero_flag, carry_flag}, 16'h3);
      exec(16'h1421, 0);                       // 0001 - FFFF
      rd_reg(4'd4, v); chk("sub_r4", v, 16'h0002);
      chk("sub_flags", {14'h0, zero_flag, carry_flag}, 16'h1);
      exec(16'h2511, 1);                       // FFFF ^ FFFF
      rd_reg(4'd5, v); chk("xor_r5", v, 16'h0000);
      chk("xor_flags", {14'h0, zero_flag, carry_flag}, 16'h3);

      // 4: PC wrap and load priority
      imem_data = 16'h0010;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("pc_load_ffff", imem_addr, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("pc_wrap", imem_addr, 16'h0000);
      exec(16'hF612, 0);
      chk("loadi_zero_held", {14'h0, zero_flag, carry_flag}, 16'h3);
      for (int i = 0; i < 8; i++) exec(16'h0666, 0);   // r6 <<= 8 via doubling
      exec(16'hF734, 0);
      exec(16'h0667, 0);
      rd_reg(4'd6, v); chk("build_r6", v, 16'h1234);
      imem_data = 16'h0060;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("pc_prio", imem_addr, 16'h1234);

      // 5: ins_load with reg_load uses the old IR
      imem_data = 16'hF7AB;
      cyc(1, 0, 0, 0, 0, 0, 0);
      imem_data = 16'h0912;
      cyc(1, 0, 0, 0, 1, 0, 0);
      rd_reg(4'd7, v); chk("oldir_r7", v, 16'h00AB);
      rd_reg(4'd9, v); chk("oldir_r9", v, 16'h0000);
      chk("newir_opc", {12'h0, opcode}, 16'h0);

      // 6: operand read before same-cycle write
      imem_data = 16'hF550;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 0, 0);
      rd_reg(4'd5, v); chk("rw_r5", v, 16'h0050);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("rw_op1_old", imem_addr, 16'h0000);

      // async reset mid-sequence, checked before the next edge
      cyc(0, 0, 0, 0, 0, 0, 1);
      #2 rst = 1'b1;
      dbg_sel = 4'd6;
      #1;
      chk("arst_pc", imem_addr, 16'h0000);
      chk("arst_opc", {12'h0, opcode}, 16'h0);
      chk("arst_flags", {13'h0, ir_valid, zero_flag, carry_flag}, 16'h0);
      chk("arst_r6", dbg_data, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
